// File: rtl/instr_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue_if
//
// Groups every handshake and bus signal of the instruction-fetch queue.
// The queue itself connects through the master modport. The surrounding
// environment (PC register, instruction memory and decode) connects through
// the slave modport.
//
// Signals
//   pc_i            current PC offered by the program counter
//   pc_ready        fetch of pc_i accepted this cycle (PC may advance)
//   flush           control-flow redirect, drops queued and in-flight fetches
//   imem_req_valid  fetch request valid
//   imem_req_addr   fetch address (equals pc_i)
//   imem_req_ready  memory accepts the request
//   imem_resp_valid in-order instruction response valid
//   imem_resp_data  returned instruction word
//   id_valid        id_instr/id_pc hold a valid fetched instruction
//   id_instr        instruction word to decode
//   id_pc           PC of id_instr
//   id_ready        decode consumes the head entry this cycle
// -----------------------------------------------------------------------------
interface instr_fetch_queue_if;
  logic [31:0] pc_i;
  logic        pc_ready;
  logic        flush;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;

  modport master (
    input  pc_i,
    input  flush,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  id_ready,
    output pc_ready,
    output imem_req_valid,
    output imem_req_addr,
    output id_valid,
    output id_instr,
    output id_pc
  );

  modport slave (
    output pc_i,
    output flush,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    output id_ready,
    input  pc_ready,
    input  imem_req_valid,
    input  imem_req_addr,
    input  id_valid,
    input  id_instr,
    input  id_pc
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Instruction-fetch stage between the program counter and decode. Every
// accepted PC becomes an instruction-memory request and is tracked in an
// in-order circular queue. Returned words are paired with their PC and
// handed to decode in program order. A redirect (flush) discards the whole
// queue and remembers how many responses are still owed to discarded
// fetches so that those words can be thrown away when they arrive.
//
// Parameters
//   DEPTH  queue entries, power of two, >= 2
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   bus    instr_fetch_queue_if.master (PC, memory and decode handshakes)
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Queue storage: data fields carry no reset, only the filled flags do.
  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] filled;

  logic [PW-1:0] head;
  logic [PW-1:0] alloc;
  logic [PW-1:0] fill;
  logic [CW-1:0] count;
  logic [CW-1:0] drop_cnt;

  logic [CW-1:0]    unfilled;
  logic [DEPTH-1:0] filled_nxt;
  logic             req_valid;
  logic             push;
  logic             id_valid;
  logic             pop;
  logic             resp_drop;
  logic             resp_fill;
  logic             resp_orphan;

  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  always_comb begin
    // Allocated entries still waiting for their word. Filled flags are only
    // ever set on allocated entries and cleared on pop, so the difference is
    // exact even when the pointers alias on a full queue.
    unfilled = count - popcount(filled);

    // Owed responses occupy capacity just like live entries, otherwise a
    // fresh fetch could be matched with a stale word.
    req_valid = rst && !bus.flush &&
                (({1'b0, count} + {1'b0, drop_cnt}) < {1'b0, DEPTH_C});
    push      = req_valid && bus.imem_req_ready;

    id_valid  = filled[head] && (count != '0) && !bus.flush;
    pop       = id_valid && bus.id_ready;

    // Responses first pay off the debt left by a flush, then fill in order.
    resp_drop   = bus.imem_resp_valid && (drop_cnt != '0);
    resp_fill   = bus.imem_resp_valid && (drop_cnt == '0) && (unfilled != '0);
    resp_orphan = bus.imem_resp_valid && (drop_cnt == '0) && (unfilled == '0);

    filled_nxt = filled;
    if (resp_fill) filled_nxt[fill] = 1'b1;
    if (pop)       filled_nxt[head] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head     <= '0;
      alloc    <= '0;
      fill     <= '0;
      count    <= '0;
      drop_cnt <= '0;
      filled   <= '0;
    end else if (bus.flush) begin
      // Every unfilled entry becomes an owed response, except one whose word
      // is arriving right now: that word is discarded here and never owed.
      drop_cnt <= drop_cnt + unfilled - CW'(resp_drop || resp_fill);
      count    <= '0;
      filled   <= '0;
      head     <= alloc;
      fill     <= alloc;
    end else begin
      if (push)      alloc    <= alloc + 1'b1;
      if (resp_fill) fill     <= fill + 1'b1;
      if (pop)       head     <= head + 1'b1;
      if (resp_drop) drop_cnt <= drop_cnt - 1'b1;
      count  <= count + CW'(push) - CW'(pop);
      filled <= filled_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) pc_q[alloc] <= bus.pc_i;
    if (resp_fill && !bus.flush) instr_q[fill] <= bus.imem_resp_data;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = bus.pc_i;
  assign bus.pc_ready       = push;
  assign bus.id_valid       = id_valid;
  assign bus.id_instr       = instr_q[head];
  assign bus.id_pc          = pc_q[head];

  // A word with nothing waiting for it means the memory broke ordering.
  resp_without_fetch: assert property (@(posedge clk) disable iff (!rst)
    !resp_orphan);

  occupancy_bound: assert property (@(posedge clk) disable iff (!rst)
    (({1'b0, count} + {1'b0, drop_cnt}) <= {1'b0, DEPTH_C}));

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_queue_if bus ();

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } mem_t;

  mem_t        mem_q[$];
  logic [31:0] sb_q[$];

  int errors = 0;
  int checks = 0;

  int          cyc;
  int          lat;
  int          last_due;
  logic        req_ready_ctl;
  logic        id_ready_ctl;
  logic        flush_ctl;
  logic [31:0] pc_model;
  logic [31:0] redirect_pc;
  int          handshakes;
  int          delivered;
  logic        got_first;
  logic [31:0] first_pc;

  logic        s_req_valid;
  logic        s_pc_ready;
  logic        s_id_valid;
  logic [31:0] s_addr;
  logic [31:0] s_id_pc;
  logic [31:0] s_id_instr;

  // One clock cycle: drive inputs just after the rising edge, observe at the
  // falling edge, run the memory model and scoreboard, then move on.
  task automatic tick();
    int          due;
    logic [31:0] exp;
    bus.pc_i           = pc_model;
    bus.imem_req_ready = req_ready_ctl;
    bus.id_ready       = id_ready_ctl;
    bus.flush          = flush_ctl;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
    end
    @(negedge clk);
    s_req_valid = bus.imem_req_valid;
    s_pc_ready  = bus.pc_ready;
    s_id_valid  = bus.id_valid;
    s_addr      = bus.imem_req_addr;
    s_id_pc     = bus.id_pc;
    s_id_instr  = bus.id_instr;
    if (bus.pc_ready === 1'b1) begin
      handshakes++;
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{due: due, data: bus.imem_req_addr ^ KEY});
      sb_q.push_back(pc_model);
      pc_model = pc_model + 32'd4;
    end
    if (bus.id_valid === 1'b1 && id_ready_ctl === 1'b1) begin
      delivered++;
      if (!got_first) begin
        got_first = 1'b1;
        first_pc  = bus.id_pc;
      end
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: delivered pc=%h with nothing expected", bus.id_pc);
      end else begin
        exp = sb_q.pop_front();
        if (bus.id_pc !== exp || bus.id_instr !== (exp ^ KEY)) begin
          errors++;
          $display("FAIL sb_order: got pc=%h instr=%h, expected pc=%h instr=%h",
                   bus.id_pc, bus.id_instr, exp, exp ^ KEY);
        end
      end
    end
    if (flush_ctl) begin
      sb_q.delete();
      pc_model = redirect_pc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic assert_reset();
    rst                 = 1'b0;
    bus.pc_i            = '0;
    bus.flush           = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.id_ready        = 1'b0;
    mem_q.delete();
    sb_q.delete();
    pc_model      = '0;
    redirect_pc   = '0;
    cyc           = 0;
    last_due      = -1;
    lat           = 1;
    req_ready_ctl = 1'b1;
    id_ready_ctl  = 1'b1;
    flush_ctl     = 1'b0;
    handshakes    = 0;
    delivered     = 0;
    got_first     = 1'b0;
    first_pc      = '0;
  endtask

  task automatic do_reset();
    assert_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Steady stream straight out of reset, 1-cycle memory, decode always ready.
  task automatic run_stream(input string tag);
    logic exp_idv;
    lat = 1; req_ready_ctl = 1'b1; id_ready_ctl = 1'b1; flush_ctl = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++;
      if (s_req_valid !== 1'b1 || s_pc_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s_req_every_cycle c=%0d: got valid=%b ready=%b, expected 1/1",
                 tag, c, s_req_valid, s_pc_ready);
      end
      if (c == 1) begin
        checks++;
        if (s_addr !== 32'h0) begin
          errors++;
          $display("FAIL %s_first_addr: got %h, expected 00000000", tag, s_addr);
        end
      end
      exp_idv = (c >= 3);
      checks++;
      if (s_id_valid !== exp_idv) begin
        errors++;
        $display("FAIL %s_id_valid c=%0d: got %b, expected %b", tag, c, s_id_valid, exp_idv);
      end
      if (c == 3) begin
        checks++;
        if (s_id_pc !== 32'h0 || s_id_instr !== 32'hA5A5_0000) begin
          errors++;
          $display("FAIL %s_first_instr: got pc=%h instr=%h, expected 00000000/a5a50000",
                   tag, s_id_pc, s_id_instr);
        end
      end
    end
    checks++;
    if (delivered !== 10) begin
      errors++;
      $display("FAIL %s_delivered: got %0d, expected 10", tag, delivered);
    end
  endtask

  task automatic test_reset();
    #2;
    assert_reset();
    bus.imem_req_ready = 1'b1;
    bus.id_ready       = 1'b1;
    #3;
    checks++;
    if (bus.imem_req_valid !== 1'b0 || bus.pc_ready !== 1'b0 || bus.id_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got req_valid=%b pc_ready=%b id_valid=%b, expected 0/0/0",
               bus.imem_req_valid, bus.pc_ready, bus.id_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.count !== '0 || dut.drop_cnt !== '0 || dut.filled !== '0) begin
      errors++;
      $display("FAIL reset_state: got count=%0d drop=%0d filled=%b, expected 0/0/0",
               dut.count, dut.drop_cnt, dut.filled);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    run_stream("stream");
  endtask

  task automatic test_decode_stall();
    do_reset();
    id_ready_ctl = 1'b0;
    repeat (8) tick();
    checks++;
    if (handshakes !== 4) begin
      errors++;
      $display("FAIL stall_req_count: got %0d, expected 4", handshakes);
    end
    checks++;
    if (s_req_valid !== 1'b0 || s_pc_ready !== 1'b0 || pc_model !== 32'h10) begin
      errors++;
      $display("FAIL stall_full: got req_valid=%b pc_ready=%b pc=%h, expected 0/0/00000010",
               s_req_valid, s_pc_ready, pc_model);
    end
    id_ready_ctl = 1'b1;
    tick();
    checks++;
    if (s_id_valid !== 1'b1 || s_id_pc !== 32'h0 || s_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got id_valid=%b pc=%h req_valid=%b, expected 1/00000000/0",
               s_id_valid, s_id_pc, s_req_valid);
    end
    tick();
    checks++;
    if (s_req_valid !== 1'b1 || s_addr !== 32'h10) begin
      errors++;
      $display("FAIL stall_resume: got req_valid=%b addr=%h, expected 1/00000010",
               s_req_valid, s_addr);
    end
    repeat (8) tick();
    checks++;
    if (delivered < 5) begin
      errors++;
      $display("FAIL stall_delivered: got %0d, expected at least 5", delivered);
    end
  endtask

  task automatic test_flush_inflight();
    do_reset();
    lat = 3;
    tick();
    tick();
    req_ready_ctl = 1'b0; flush_ctl = 1'b1; redirect_pc = 32'h100;
    tick();
    checks++;
    if (s_id_valid !== 1'b0 || dut.drop_cnt !== 3'd2) begin
      errors++;
      $display("FAIL flush_drop: got id_valid=%b drop_cnt=%0d, expected 0/2",
               s_id_valid, dut.drop_cnt);
    end
    flush_ctl = 1'b0; req_ready_ctl = 1'b1;
    tick();
    checks++;
    if (s_id_valid !== 1'b0 || s_req_valid !== 1'b1 || s_addr !== 32'h100) begin
      errors++;
      $display("FAIL flush_redirect: got id_valid=%b req_valid=%b addr=%h, expected 0/1/00000100",
               s_id_valid, s_req_valid, s_addr);
    end
    repeat (12) tick();
    checks++;
    if (got_first !== 1'b1 || first_pc !== 32'h100 || dut.drop_cnt !== '0) begin
      errors++;
      $display("FAIL flush_first_pc: got seen=%b pc=%h drop=%0d, expected 1/00000100/0",
               got_first, first_pc, dut.drop_cnt);
    end
  endtask

  task automatic test_flush_resp();
    do_reset();
    lat = 2;
    tick();
    tick();
    flush_ctl = 1'b1; redirect_pc = 32'h200;
    tick();
    checks++;
    if (s_req_valid !== 1'b0 || s_pc_ready !== 1'b0 || dut.drop_cnt !== 3'd1) begin
      errors++;
      $display("FAIL flushresp_drop: got req_valid=%b pc_ready=%b drop=%0d, expected 0/0/1",
               s_req_valid, s_pc_ready, dut.drop_cnt);
    end
    flush_ctl = 1'b0;
    repeat (10) tick();
    checks++;
    if (got_first !== 1'b1 || first_pc !== 32'h200 || dut.drop_cnt !== '0) begin
      errors++;
      $display("FAIL flushresp_first_pc: got seen=%b pc=%h drop=%0d, expected 1/00000200/0",
               got_first, first_pc, dut.drop_cnt);
    end
  endtask

  task automatic test_mem_backpressure();
    logic [3:0]  pat;
    logic [31:0] exp_addr;
    do_reset();
    pat = 4'b1001;
    for (int c = 0; c < 16; c++) begin
      req_ready_ctl = pat[c % 4];
      exp_addr = pc_model;
      tick();
      checks++;
      if (s_req_valid !== 1'b1 || s_pc_ready !== req_ready_ctl || s_addr !== exp_addr) begin
        errors++;
        $display("FAIL bp_handshake c=%0d: got valid=%b pc_ready=%b addr=%h, expected 1/%b/%h",
                 c, s_req_valid, s_pc_ready, s_addr, req_ready_ctl, exp_addr);
      end
    end
    req_ready_ctl = 1'b0;
    repeat (4) tick();
    checks++;
    if (delivered !== 8 || handshakes !== 8) begin
      errors++;
      $display("FAIL bp_count: got delivered=%0d issued=%0d, expected 8/8", delivered, handshakes);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    id_ready_ctl = 1'b0;
    repeat (3) tick();
    req_ready_ctl = 1'b0;
    tick();
    bus.imem_req_ready  = 1'b1;
    bus.id_ready        = 1'b0;
    bus.flush           = 1'b0;
    bus.imem_resp_valid = 1'b0;
    #2;
    checks++;
    if (bus.id_valid !== 1'b1 || bus.imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_before: got id_valid=%b req_valid=%b, expected 1/1",
               bus.id_valid, bus.imem_req_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || bus.pc_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: got id_valid=%b req_valid=%b pc_ready=%b, expected 0/0/0",
               bus.id_valid, bus.imem_req_valid, bus.pc_ready);
    end
    assert_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    run_stream("restream");
  endtask

  initial begin
    test_reset();
    test_decode_stall();
    test_flush_inflight();
    test_flush_resp();
    test_mem_backpressure();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
